// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Receive-side decoder for a multiplexed 4-digit 7-segment
//                display bus. Captures each digit after a stable dwell,
//                decodes it to BCD, and converts each complete frame to a
//                14-bit binary value with a one-cycle VALID (or ERR) strobe.
//  Options     : SEG7DEC_BLANK_ZERO_EN - decode all-off (1111111) as digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SEG7OUT,
  input  logic [3:0]  SEG7COM,
  output logic [13:0] BIN,
  output logic [3:0]  THOUSANDS,
  output logic [3:0]  HUNDREDS,
  output logic [3:0]  TENS,
  output logic [3:0]  ONES,
  output logic        VALID,
  output logic        ERR
);

  localparam int c_CNT_W = $clog2(SETTLE + 1);
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONV    = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [6:0]          r_seg_meta, r_seg_sync;
  logic [3:0]          r_com_meta, r_com_sync;
  logic [10:0]         r_prev;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_TMO_W-1:0]  r_tmo;
  logic [3:0]          r_mask;
  logic                r_err;
  logic [3:0][3:0]     r_dig;      // index 0 = thousands ... 3 = ones
  logic [1:0]          r_step;
  logic [13:0]         r_acc;

  logic [10:0]         w_cur;
  logic                w_same;
  logic                w_onehot;
  logic [1:0]          w_idx;
  logic [3:0]          w_dbit;
  logic                w_capture;
  logic                w_mask_full;
  logic [4:0]          w_dec;
  logic [13:0]         w_acc_next;

  // Decode an active-low segment pattern to {invalid, digit}.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: f_decode = {1'b0, 4'd0};
      7'b1111001: f_decode = {1'b0, 4'd1};
      7'b0100100: f_decode = {1'b0, 4'd2};
      7'b0110000: f_decode = {1'b0, 4'd3};
      7'b0011001: f_decode = {1'b0, 4'd4};
      7'b0010010: f_decode = {1'b0, 4'd5};
      7'b0000010: f_decode = {1'b0, 4'd6};
      7'b1111000: f_decode = {1'b0, 4'd7};
      7'b0000000: f_decode = {1'b0, 4'd8};
      7'b0010000: f_decode = {1'b0, 4'd9};
`ifdef SEG7DEC_BLANK_ZERO_EN
      7'b1111111: f_decode = {1'b0, 4'd0};
`else
      7'b1111111: f_decode = {1'b1, 4'hF};
`endif
      default:    f_decode = {1'b1, 4'hF};
    endcase
  endfunction

  // Two-flop synchronizer; idles high so reset looks like a blank bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seg_meta <= 7'h7F;
      r_seg_sync <= 7'h7F;
      r_com_meta <= 4'hF;
      r_com_sync <= 4'hF;
    end else begin
      r_seg_meta <= SEG7OUT;
      r_seg_sync <= r_seg_meta;
      r_com_meta <= SEG7COM;
      r_com_sync <= r_com_meta;
    end
  end

  assign w_cur  = {r_com_sync, r_seg_sync};
  assign w_same = (w_cur == r_prev);

  // Stability counter: counts matching cycles, saturates at SETTLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev <= 11'h7FF;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_cur;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != c_CNT_W'(SETTLE))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Map the active-low common to a digit index; only one low bit is legal.
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_com_sync)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_dbit      = ~r_com_sync;
  assign w_dec       = f_decode(r_seg_sync);
  // The current sample must also match, so a dwell needs SETTLE+1 cycles.
  assign w_capture   = w_same && (r_cnt == c_CNT_W'(SETTLE - 1)) && w_onehot
                       && (r_state == ST_COLLECT);
  assign w_mask_full = ((r_mask | w_dbit) == 4'hF);
  assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {10'd0, r_dig[r_step]};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_COLLECT;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_capture && w_mask_full) w_state_next = ST_CONV;
      ST_CONV:    if (r_step == 2'd3)           w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_COLLECT;
      default:    w_state_next = ST_COLLECT;
    endcase
  end

  // Frame collection, timeout and BCD-to-binary accumulation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dig  <= '0;
      r_mask <= 4'h0;
      r_err  <= 1'b0;
      r_tmo  <= '0;
      r_step <= 2'd0;
      r_acc  <= 14'd0;
    end else begin
      if (w_capture) begin
        r_dig[w_idx] <= w_dec[3:0];
        r_mask       <= r_mask | w_dbit;
        r_tmo        <= '0;
        r_acc        <= 14'd0;
        r_step       <= 2'd0;
        if (w_dec[4]) r_err <= 1'b1;
      end else if ((r_state == ST_COLLECT) && (r_mask != 4'h0)) begin
        if (r_tmo == c_TMO_W'(TIMEOUT - 1)) begin
          r_mask <= 4'h0;
          r_err  <= 1'b0;
          r_tmo  <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
      if (r_state == ST_CONV) begin
        r_acc  <= w_acc_next;
        r_step <= r_step + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_mask <= 4'h0;
        r_err  <= 1'b0;
      end
    end
  end

  // Outputs update on entry to DONE so the strobe is high during DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BIN       <= 14'd0;
      THOUSANDS <= 4'd0;
      HUNDREDS  <= 4'd0;
      TENS      <= 4'd0;
      ONES      <= 4'd0;
      VALID     <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if ((r_state == ST_CONV) && (r_step == 2'd3)) begin
        if (r_err) begin
          ERR <= 1'b1;
        end else begin
          VALID     <= 1'b1;
          BIN       <= w_acc_next;
          THOUSANDS <= r_dig[0];
          HUNDREDS  <= r_dig[1];
          TENS      <= r_dig[2];
          ONES      <= r_dig[3];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Scoreboard bench for seg7_scan_decoder. Frame results are
//                queued when stimulus is driven and compared on VALID/ERR.
//  Options     : SEG7DEC_BLANK_ZERO_EN changes the expectation for blanks
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;
  localparam logic [3:0] c_TH = 4'b1110, c_HU = 4'b1101, c_TE = 4'b1011,
                         c_ON = 4'b0111, c_IDLE = 4'b1111;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  SEG7OUT;
  logic [3:0]  SEG7COM;
  logic [13:0] BIN;
  logic [3:0]  THOUSANDS, HUNDREDS, TENS, ONES;
  logic        VALID, ERR;

  typedef struct packed {
    logic        is_err;
    logic [13:0] bin;
    logic [15:0] dig;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [13:0] exp_last_bin;
  logic [15:0] exp_last_dig;
  logic        prev_pulse;

  always #5 CLK = ~CLK;

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .SEG7OUT(SEG7OUT), .SEG7COM(SEG7COM),
    .BIN(BIN), .THOUSANDS(THOUSANDS), .HUNDREDS(HUNDREDS), .TENS(TENS),
    .ONES(ONES), .VALID(VALID), .ERR(ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Active-low patterns; 10 = blank, 11 = malformed.
  function automatic logic [6:0] pat(input int d);
    case (d)
      0:  pat = 7'b1000000;
      1:  pat = 7'b1111001;
      2:  pat = 7'b0100100;
      3:  pat = 7'b0110000;
      4:  pat = 7'b0011001;
      5:  pat = 7'b0010010;
      6:  pat = 7'b0000010;
      7:  pat = 7'b1111000;
      8:  pat = 7'b0000000;
      9:  pat = 7'b0010000;
      10: pat = 7'b1111111;
      default: pat = 7'b0111111;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic show(input logic [3:0] com, input int d, input int n);
    SEG7COM = com;
    SEG7OUT = pat(d);
    cyc(n);
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    show(c_TH, a, 20);
    show(c_HU, b, 20);
    show(c_TE, c, 20);
    show(c_ON, d, 20);
    show(c_IDLE, 10, 10);
  endtask

  task automatic expect_ok(input int a, input int b, input int c, input int d);
    exp_t e;
    e.is_err = 1'b0;
    e.bin    = 14'(a * 1000 + b * 100 + c * 10 + d);
    e.dig    = {4'(a), 4'(b), 4'(c), 4'(d)};
    exp_last_bin = e.bin;
    exp_last_dig = e.dig;
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.bin    = exp_last_bin;
    e.dig    = exp_last_dig;
    q.push_back(e);
  endtask

  // Monitor: every strobe pops one expectation.
  initial begin
    prev_pulse = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        prev_pulse = 1'b0;
      end else begin
        if (VALID || ERR) begin
          check("strobe_gap", {31'd0, prev_pulse}, 32'd0);
          if (q.size() == 0) begin
            check("unexpected_strobe", {30'd0, VALID, ERR}, 32'd0);
          end else begin
            mon_e = q.pop_front();
            check("strobe_kind", {30'd0, VALID, ERR}, mon_e.is_err ? 32'd1 : 32'd2);
            check("bin", {18'd0, BIN}, {18'd0, mon_e.bin});
            check("digits", {16'd0, THOUSANDS, HUNDREDS, TENS, ONES}, {16'd0, mon_e.dig});
          end
        end
        prev_pulse = VALID || ERR;
      end
    end
  end

  initial begin
    RST = 1'b1;
    SEG7COM = c_IDLE;
    SEG7OUT = 7'h7F;
    exp_last_bin = 14'd0;
    exp_last_dig = 16'd0;
    cyc(3);
    check("rst_bin",    {18'd0, BIN}, 32'd0);
    check("rst_digits", {16'd0, THOUSANDS, HUNDREDS, TENS, ONES}, 32'd0);
    check("rst_valid",  {31'd0, VALID}, 32'd0);
    check("rst_err",    {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    cyc(5);

    // Nominal and extreme values.
    expect_ok(1, 2, 3, 4); frame(1, 2, 3, 4);
    expect_ok(9, 9, 9, 9); frame(9, 9, 9, 9);
    expect_ok(0, 0, 0, 7); frame(0, 0, 0, 7);

    // Short hundreds pulse must not fill the mask before the real hundreds.
    expect_ok(5, 0, 0, 0);
    show(c_TH, 5, 20);
    show(c_HU, 9, 2);
    show(c_IDLE, 10, 10);
    show(c_TE, 0, 20);
    show(c_ON, 0, 20);
    show(c_HU, 0, 20);
    show(c_IDLE, 10, 10);

    // Malformed tens pattern rejects the frame; BIN keeps 1234.
    expect_ok(1, 2, 3, 4); frame(1, 2, 3, 4);
    expect_err();          frame(1, 2, 11, 4);
    check("bin_hold_after_err", {18'd0, BIN}, 32'd1234);

    // Two commons low at once is ignored.
    expect_ok(1, 2, 3, 6);
    show(c_TH, 1, 20);
    show(c_HU, 2, 20);
    show(c_TE, 3, 20);
    show(4'b1100, 8, 20);
    show(c_ON, 6, 20);
    show(c_IDLE, 10, 10);

    // Reset while converting: no strobe, outputs cleared.
    show(c_TH, 8, 20);
    show(c_HU, 8, 20);
    show(c_TE, 8, 20);
    show(c_ON, 8, 8);
    RST = 1'b1;
    cyc(1);
    check("rst_conv_bin",   {18'd0, BIN}, 32'd0);
    check("rst_conv_valid", {31'd0, VALID}, 32'd0);
    exp_last_bin = 14'd0;
    exp_last_dig = 16'd0;
    cyc(1);
    SEG7COM = c_IDLE;
    SEG7OUT = 7'h7F;
    RST = 1'b0;
    cyc(10);
    expect_ok(4, 3, 2, 1); frame(4, 3, 2, 1);

    // Partial frame abandoned by timeout, then a fresh frame.
    show(c_TH, 9, 20);
    show(c_HU, 9, 20);
    show(c_TE, 9, 20);
    show(c_IDLE, 10, TIMEOUT + 30);
    expect_ok(2, 3, 4, 1);
    show(c_ON, 1, 20);
    show(c_TH, 2, 20);
    show(c_HU, 3, 20);
    show(c_TE, 4, 20);
    show(c_IDLE, 10, 10);

    // Leading blanks.
`ifdef SEG7DEC_BLANK_ZERO_EN
    expect_ok(0, 0, 4, 2);
`else
    expect_err();
`endif
    frame(10, 10, 4, 2);

    cyc(20);
    check("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
